alu32_mult_seq: RTL and testbench

- Sequential 32x32 unsigned shift-add multiplier producing a 64-bit product.
- Sits directly upstream of the ALU's 32-bit ripple adder (fulladder_32bit) and drives it. Each iteration feeds the adder one partial-product addition and consumes its sum and carry_out.
- Provides a start/busy/done handshake so the ALU control can issue a multiply and wait for the result.

---
 rtl/alu32_mult_seq.sv | 124 ++++++++++++
 tb/tb_alu32_mult_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu32_mult_seq.sv
// Sequential 32x32 unsigned shift-add multiplier with a 64-bit product.
// One partial-product addition per clock goes through a 32-bit ripple adder.
// The operation is issued with start and signalled with busy and a one-cycle done pulse.

// 32-bit ripple-carry adder: sum = a + b + carry_in, with carry_out.
module fulladder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    output logic [31:0] sum,
    output logic        carry_out
);
    // Ripple the carry one bit position at a time.
    always_comb begin
        logic [32:0] v_c;
        v_c    = '0;
        v_c[0] = carry_in;
        sum    = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i]   = a[i] ^ b[i] ^ v_c[i];
            v_c[i+1] = (a[i] & b[i]) | (a[i] & v_c[i]) | (b[i] & v_c[i]);
        end
        carry_out = v_c[32];
    end
endmodule

// Multiplier controller and datapath.
// Handshake: start is looked at only while idle. The edge that sees start=1 in
// IDLE captures A and B. busy is high for the 32 iteration cycles that follow.
// done then pulses for one cycle, and the product outputs are final at that
// point. The product outputs hold their value until the next result or a reset.
module alu32_mult_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_m;      // multiplicand
    logic [2*WIDTH-1:0] r_p;      // {partial sum, remaining multiplier bits}
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_carry;
    logic [2*WIDTH-1:0] w_p_next;

    // The next multiplier bit decides whether the multiplicand is added this step.
    assign w_addend  = r_p[0] ? r_m : '0;
    assign w_p_next  = {w_carry, w_sum, r_p[WIDTH-1:1]};
    assign dbg_state = r_state;

    fulladder_32bit u_adder (
        .a         (r_p[2*WIDTH-1:WIDTH]),
        .b         (w_addend),
        .carry_in  (1'b0),
        .sum       (w_sum),
        .carry_out (w_carry)
    );

    // Control FSM and datapath. Registered busy, done and product outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_m        <= '0;
            r_p        <= '0;
            r_cnt      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            product_hi <= '0;
            product_lo <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_m     <= A;
                        r_p     <= {{WIDTH{1'b0}}, B};
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // The 32nd iteration publishes the fully shifted accumulator.
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        product_hi <= w_p_next[2*WIDTH-1:WIDTH];
                        product_lo <= w_p_next[WIDTH-1:0];
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A start seen here is dropped; it must be re-presented in IDLE.
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu32_mult_seq.sv
// Testbench for alu32_mult_seq. A transaction-level model predicts busy, done
// and product each cycle. Directed vectors carry hand-computed products.
module tb_alu32_mult_seq;
    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Reference model: an accepted request completes 32 edges later with A*B.
    int          m_left = 0;
    bit          m_done = 0;
    logic [63:0] m_prod = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;

    alu32_mult_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .product_hi (product_hi),
        .product_lo (product_lo),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Model update on each rising edge
    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_done = 0;
            m_prod = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1;
                m_prod = 64'(m_a) * 64'(m_b);
            end
        end else if (start) begin
            m_left = 32;
            m_a    = A;
            m_b    = B;
        end
    end

    // Cycle compare on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (busy !== (m_left > 0) || done !== m_done ||
                {product_hi, product_lo} !== m_prod) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t: busy=%b done=%b prod=%h expected busy=%b done=%b prod=%h",
                         $time, busy, done, {product_hi, product_lo}, (m_left > 0), m_done, m_prod);
            end
        end
    end

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one multiply and wait for done. Done must follow 32 edges after
    // the accepting edge, at the end of the 32nd iteration. The task returns
    // after the DONE->IDLE edge, so the next call is accepted back-to-back.
    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A = $urandom; B = $urandom;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
        check_val({name, "_latency"}, 64'(n), 64'd32);
        check_val({name, "_product"}, {product_hi, product_lo}, exp);
        @(posedge clk);
        #1;
        check_val({name, "_done_width"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; start = 1'b1; A = 32'h1; B = 32'h1;
        @(posedge clk);
        chk_en = 1;
        @(posedge clk);
        #1;
        check_val("reset_busy", {63'd0, busy}, 64'd0);
        check_val("reset_done", {63'd0, done}, 64'd0);
        check_val("reset_product", {product_hi, product_lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;

        run_mul("mul_3x5", 32'h3, 32'h5, 64'h0000_0000_0000_000F);
        run_mul("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_mul("mul_zero", 32'h0, 32'h1234_5678, 64'h0);
        run_mul("mul_msb", 32'h8000_0000, 32'h2, 64'h0000_0001_0000_0000);
        run_mul("mul_shift", 32'hDEAD_BEEF, 32'h10, 64'h0000_000D_EADB_EEF0);
        run_mul("mul_ones", 32'hFFFF_FFFF, 32'h1, 64'h0000_0000_FFFF_FFFF);

        // A second request during RUN with new operands is ignored.
        @(negedge clk);
        A = 32'd7; B = 32'd6; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        A = 32'd9; B = 32'd9; start = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                start = 1'b0;
                check_val("busy_req_product", {product_hi, product_lo}, 64'h2A);
                break;
            end
        end
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_val("busy_req_pulses", 64'(pulses), 64'd1);

        // Reset sampled on the 10th RUN edge discards the operation.
        @(negedge clk);
        A = 32'hFFFF_FFFF; B = 32'h2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrun_reset_busy", {63'd0, busy}, 64'd0);
        check_val("midrun_reset_product", {product_hi, product_lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_val("midrun_reset_no_done", 64'(pulses), 64'd0);

        run_mul("mul_after_reset", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);

        repeat (3) @(negedge clk);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
